// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with count-based full/empty flags,
// run-time almost-full/almost-empty thresholds and overflow/underflow pulses.
module fifo_param #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   umb_almost_full,
  input  logic [ADDR_WIDTH:0]   umb_almost_empty,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE_C = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;
  logic [ADDR_WIDTH:0]   count_next_s;

  // Acceptance uses registered state; a full FIFO may take a push only when a pop frees the head slot.
  always_comb begin
    push_ok_s    = push & (~fifo_full | pop);
    pop_ok_s     = pop & ~fifo_empty;
    count_next_s = data_count;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = data_count + CNT_ONE_C;
      2'b01:   count_next_s = data_count - CNT_ONE_C;
      default: count_next_s = data_count;
    endcase
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Pointers, counter, read port, error pulses and status flags.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      data_count   <= '0;
      data_out     <= '0;
      valid        <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      fifo_full    <= 1'b0;
      fifo_empty   <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      // Old head is read here even when the same slot is rewritten this edge.
      if (pop_ok_s) begin
        data_out <= mem_r[rd_ptr_r];
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      valid        <= pop_ok_s;
      overflow     <= push & ~push_ok_s;
      underflow    <= pop & ~pop_ok_s;
      data_count   <= count_next_s;
      fifo_full    <= (count_next_s == DEPTH_C);
      fifo_empty   <= (count_next_s == '0);
      almost_full  <= (count_next_s >= umb_almost_full);
      almost_empty <= (count_next_s <= umb_almost_empty);
    end
  end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO, the next generation of the team's single-clock queue, with storage, pointers and status flags in one block. Data width and depth are set by parameters, and the almost-full/almost-empty thresholds are programmable at run time. Simultaneous push/pop is handled correctly at every fill level, and illegal accesses raise error pulses. It sits between the lane demux and the output arbiter and buffers one channel per instance.

## Interface
- DATA_WIDTH, 6, bits per entry
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH entries (default 8)
- clk  input  1  single clock; all logic on rising edge
- reset_L  input  1  asynchronous, active-low reset
- push  input  1  write request, sampled at rising edge
- pop  input  1  read request, sampled at rising edge
- data_in  input  DATA_WIDTH  data written on an accepted push
- umb_almost_full  input  ADDR_WIDTH+1  almost-full threshold, legal range 1..DEPTH
- umb_almost_empty  input  ADDR_WIDTH+1  almost-empty threshold, legal range 0..DEPTH-1
- data_out  output  DATA_WIDTH  head entry delivered by an accepted pop; holds between pops
- valid  output  1  high for exactly the cycle after each accepted pop
- fifo_full  output  1  data_count == DEPTH
- fifo_empty  output  1  data_count == 0
- almost_full  output  1  data_count >= umb_almost_full
- almost_empty  output  1  data_count <= umb_almost_empty
- data_count  output  ADDR_WIDTH+1  entries currently stored, 0..DEPTH
- overflow  output  1  one-cycle pulse: push rejected
- underflow  output  1  one-cycle pulse: pop rejected

## Operation
- Storage is a DEPTH x DATA_WIDTH register array, with wr_ptr and rd_ptr of ADDR_WIDTH bits each.
  - Pointers wrap modulo DEPTH naturally; no special case at the wrap.
  - Full and empty are decided from data_count, never from pointer equality.
- Acceptance is evaluated on the current registered state:
  - push_ok = push & (!fifo_full | pop)
  - pop_ok = pop & !fifo_empty
- When full, a simultaneous push and pop are both accepted. The pop reads the old head, the push writes the freed slot, and data_count stays at DEPTH.
- When empty, a simultaneous push and pop accept only the push. data_count goes 0→1 and underflow pulses. There is no fall-through.
- When neither full nor empty, a simultaneous push and pop are both accepted and data_count is unchanged.
- Counter update: data_count_next = data_count + push_ok − pop_ok, always within 0..DEPTH.
- Accepted push: mem[wr_ptr] ← data_in, then wr_ptr+1.
- Accepted pop: data_out ← mem[rd_ptr], valid ← 1, then rd_ptr+1. Otherwise valid ← 0 and data_out holds.
- Rejected push (push & !push_ok): overflow ← 1 for one cycle. Stored data and the pointers are untouched.
- Rejected pop (pop & !pop_ok): underflow ← 1 for one cycle.
- All four flags are registered and computed from data_count_next and the current thresholds. The flags are therefore always consistent with data_count in the same cycle.
- Threshold changes take effect at the next edge. Out-of-range thresholds give unspecified almost_* values but must not corrupt data.

## Timing
- Reset (reset_L low, asynchronous) forces:
  - data_count=0, pointers=0, data_out=0
  - valid=0, overflow=0, underflow=0
  - fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0
  - Memory contents are not reset.
- Reset asserted mid-operation discards all stored entries immediately. A push or pop sampled at the first edge after release is processed normally.
- Write-to-read latency: a push at edge N makes the entry poppable at edge N+1. Its data appears on data_out after edge N+1, with valid high.
- All outputs change only on a clk rising edge or on reset assertion.
- Throughput is one push and one pop per cycle, sustained.

## Test plan
- Reset then idle, thresholds almost_full=6, almost_empty=1:
  - Required: data_count=0, fifo_empty=1, almost_empty=1, all other outputs 0.
  - Assert reset_L low between edges → outputs return to reset values without waiting for a clock edge.
- Push 8 entries 0x01..0x08 on consecutive cycles:
  - almost_empty falls after the 2nd push.
  - almost_full rises after the 6th push.
  - fifo_full=1 and data_count=8 after the 8th.
  - A 9th push → overflow pulses one cycle and data_count stays 8.
- From full, push 0x2A and pop in the same cycle:
  - data_out=0x01, valid=1, data_count stays 8, fifo_full stays 1.
  - Then 8 pops return 0x02..0x08, 0x2A in order.
- From empty, push 0x15 and pop in the same cycle:
  - underflow pulses, valid=0, data_count=1.
  - Next-cycle pop → data_out=0x15, valid=1, fifo_empty=1.
- Wrap-around: 20 cycles of simultaneous push/pop holding 3 entries, with incrementing data.
  - Required: output sequence strictly in order, data_count constant at 3, no error pulses.
- Reset mid-stream with 5 entries stored:
  - Required: fifo_empty=1 and data_count=0 immediately.
  - A subsequent push 0x33 then pop → data_out=0x33.
